// File: rtl/core_switch_arbiter_pkg.sv
// Shared types for the redundant-core switch: owner FSM states and the
// round-robin healthy-channel search used by the owner selection logic.
package core_switch_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic [1:0] {INIT, ACTIVE, ALL_FAIL} state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] id;
    } rr_sel_t;

    // First set bit of mask at or after start, wrapping within n channels.
    function automatic rr_sel_t rr_next(input logic [MAX_CH-1:0] mask, input int start, input int n);
        rr_sel_t r;
        int      idx;
        r = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            idx = (start + i) % n;
            if (i < n && !r.found && mask[idx]) begin
                r.found = 1'b1;
                r.id    = 4'(idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/core_switch_arbiter_hb_watchdog.sv
// One heartbeat channel: synchroniser, either-edge detector, saturating
// watchdog counter, seen flag and the timed reset request for the CPU.
module hb_watchdog #(
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 20,
    parameter int RESET_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic hb,
    input  logic fail_trig,
    output logic healthy,
    output logic hb_strobe,
    output logic reset_req
);

    localparam int RC_W = $clog2(RESET_CYC + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;

    assign hb_strobe = sync2_q ^ prev_q;
    assign reset_req = (rst_cnt_q != '0);
    assign healthy   = seen_q & (cnt_q < CNT_W'(TIMEOUT)) & ~reset_req;

    always_comb begin
        sync1_d = hb;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        cnt_d = cnt_q;
        if (hb_strobe)
            cnt_d = '0;
        else if (cnt_q < CNT_W'(TIMEOUT))
            cnt_d = cnt_q + CNT_W'(1);

        // A CPU under reset must prove itself with a fresh heartbeat afterwards.
        seen_d = seen_q;
        if (hb_strobe)
            seen_d = 1'b1;
        if (reset_req || fail_trig)
            seen_d = 1'b0;

        rst_cnt_d = rst_cnt_q;
        if (fail_trig)
            rst_cnt_d = RC_W'(RESET_CYC);
        else if (reset_req)
            rst_cnt_d = rst_cnt_q - RC_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            seen_q    <= 1'b0;
            cnt_q     <= '0;
            rst_cnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            seen_q    <= seen_d;
            cnt_q     <= cnt_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

endmodule

// File: rtl/core_switch_arbiter.sv
// N-channel heartbeat monitor and active-CPU selector: owner FSM with
// round-robin failover, forced-switch handshake and post-switch holdoff.
module core_switch_arbiter
    import core_switch_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int IDW       = $clog2(NCH),
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 20,
    parameter int HOLDOFF   = 8,
    parameter int RESET_CYC = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] hb,
    input  logic           force_valid,
    input  logic [IDW-1:0] force_id,
    output logic           force_ready,
    output logic           force_ack,
    output logic           force_nak,
    output logic [IDW-1:0] active_id,
    output logic           active_valid,
    output logic [NCH-1:0] healthy,
    output logic [NCH-1:0] reset_req,
    output logic           switch_pulse,
    output logic           all_fail
);

    localparam int HO_W = $clog2(HOLDOFF + 1);

    logic [NCH-1:0]    fail_trig;
    logic [NCH-1:0]    hb_strobe_unused;

    for (genvar g = 0; g < NCH; g++) begin : g_wd
        hb_watchdog #(
            .TIMEOUT   (TIMEOUT),
            .CNT_W     (CNT_W),
            .RESET_CYC (RESET_CYC)
        ) u_wd (
            .clk       (clk),
            .rst       (rst),
            .hb        (hb[g]),
            .fail_trig (fail_trig[g]),
            .healthy   (healthy[g]),
            .hb_strobe (hb_strobe_unused[g]),
            .reset_req (reset_req[g])
        );
    end

    state_t            state_q, state_d;
    logic [IDW-1:0]    active_id_q, active_id_d;
    logic              active_valid_q, active_valid_d;
    logic              all_fail_q, all_fail_d;
    logic              switch_pulse_q, switch_pulse_d;
    logic              force_ack_q, force_ack_d;
    logic              force_nak_q, force_nak_d;
    logic [HO_W-1:0]   holdoff_q, holdoff_d;

    logic [MAX_CH-1:0] mask;
    rr_sel_t           lowest_sel, next_sel;
    logic              transfer, force_ok, restart;

    assign force_ready  = (state_q == ACTIVE);
    assign force_ack    = force_ack_q;
    assign force_nak    = force_nak_q;
    assign active_id    = active_id_q;
    assign active_valid = active_valid_q;
    assign switch_pulse = switch_pulse_q;
    assign all_fail     = all_fail_q;

    always_comb begin
        mask           = '0;
        mask[NCH-1:0]  = healthy;
        lowest_sel     = rr_next(mask, 0, NCH);
        next_sel       = rr_next(mask, int'(active_id_q) + 1, NCH);
        transfer       = force_valid & force_ready;
        force_ok       = (int'(force_id) < NCH) && healthy[force_id] && (holdoff_q == '0);

        state_d        = state_q;
        active_id_d    = active_id_q;
        active_valid_d = active_valid_q;
        all_fail_d     = all_fail_q;
        switch_pulse_d = 1'b0;
        force_ack_d    = 1'b0;
        force_nak_d    = 1'b0;
        fail_trig      = '0;
        restart        = 1'b0;

        case (state_q)
            INIT, ALL_FAIL: begin
                if (lowest_sel.found) begin
                    state_d        = ACTIVE;
                    active_id_d    = IDW'(lowest_sel.id);
                    active_valid_d = 1'b1;
                    all_fail_d     = 1'b0;
                    switch_pulse_d = 1'b1;
                    restart        = 1'b1;
                end
            end
            ACTIVE: begin
                // Owner loss outranks any forced request arriving in the same cycle.
                if (!healthy[active_id_q]) begin
                    fail_trig[active_id_q] = 1'b1;
                    force_nak_d            = transfer;
                    if (next_sel.found) begin
                        active_id_d    = IDW'(next_sel.id);
                        switch_pulse_d = 1'b1;
                        restart        = 1'b1;
                    end else begin
                        state_d        = ALL_FAIL;
                        active_valid_d = 1'b0;
                        all_fail_d     = 1'b1;
                    end
                end else if (transfer) begin
                    if (force_ok) begin
                        force_ack_d = 1'b1;
                        if (force_id != active_id_q) begin
                            active_id_d    = force_id;
                            switch_pulse_d = 1'b1;
                            restart        = 1'b1;
                        end
                    end else begin
                        force_nak_d = 1'b1;
                    end
                end
            end
            default: state_d = INIT;
        endcase

        holdoff_d = holdoff_q;
        if (restart)
            holdoff_d = HO_W'(HOLDOFF);
        else if (holdoff_q != '0)
            holdoff_d = holdoff_q - HO_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= INIT;
            active_id_q    <= '0;
            active_valid_q <= 1'b0;
            all_fail_q     <= 1'b0;
            switch_pulse_q <= 1'b0;
            force_ack_q    <= 1'b0;
            force_nak_q    <= 1'b0;
            holdoff_q      <= '0;
        end else begin
            state_q        <= state_d;
            active_id_q    <= active_id_d;
            active_valid_q <= active_valid_d;
            all_fail_q     <= all_fail_d;
            switch_pulse_q <= switch_pulse_d;
            force_ack_q    <= force_ack_d;
            force_nak_q    <= force_nak_d;
            holdoff_q      <= holdoff_d;
        end
    end

endmodule
